// File: rtl/regmap_command_controller.sv
// regmap_command_controller: UART byte-command front end for a small 8-bit register map
module regmap_command_controller #(
    parameter int NUMREGS        = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       cmd_error,
    output logic [7:0] err_count
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, GET_DATA, WRITE, READ, SEND} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          addr_ok_q, tx_valid_q, reg_we_q, cmd_error_q;
    logic [7:0]    tx_data_q, reg_wdata_q, err_count_q;
    logic [3:0]    reg_addr_q;
    logic          hdr_bad, addr_bad, timeout, err_d;
    // Classify the incoming byte and decide whether this edge raises cmd_error
    always_comb begin
        hdr_bad  = rx_data[6:4] != 3'b000;
        addr_bad = {28'd0, rx_data[3:0]} >= 32'(NUMREGS);
        timeout  = state_q == GET_DATA && !rx_valid && cnt_q == CW'(TIMEOUT_CYCLES - 1);
        err_d    = timeout || (rx_valid && (state_q == IDLE ? (hdr_bad || addr_bad) : state_q != GET_DATA));
    end
    // Command sequencer; every output is registered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_ok_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            reg_addr_q  <= 4'd0;
            reg_wdata_q <= 8'd0;
            reg_we_q    <= 1'b0;
            cmd_error_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            cmd_error_q <= err_d;
            if (err_d && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            reg_we_q <= 1'b0;
            case (state_q)
                IDLE: if (rx_valid && !hdr_bad) begin
                    reg_addr_q <= rx_data[3:0];
                    addr_ok_q  <= !addr_bad;
                    cnt_q      <= '0;
                    state_q    <= rx_data[7] ? GET_DATA : READ;
                end
                GET_DATA: if (rx_valid) begin
                    reg_wdata_q <= rx_data;
                    reg_we_q    <= addr_ok_q;
                    state_q     <= WRITE;
                end else if (timeout) begin
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                WRITE: state_q <= IDLE;
                READ: begin
                    tx_data_q  <= addr_ok_q ? reg_rdata : 8'hFF;
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: if (tx_ready) begin
                    tx_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign cmd_error = cmd_error_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_regmap_command_controller.sv
// tb_regmap_command_controller: randomized scoreboard bench for the register-map command controller
module tb_regmap_command_controller;
    localparam int NR = 9;
    localparam int TO = 1024;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       cmd_error;
    logic [7:0] err_count;
    regmap_command_controller #(.NUMREGS(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_rdata(reg_rdata), .cmd_error(cmd_error), .err_count(err_count)
    );
    always #5 clk = ~clk;
    // Register map seen by the DUT
    logic [7:0] regmem [16];
    assign reg_rdata = regmem[reg_addr];
    always @(posedge clk) if (reg_we) regmem[reg_addr] <= reg_wdata;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_chk = 0;
    int n_err = 0;
    function automatic void check(string n, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, got, exp, cyc);
        end
    endfunction
    // Scoreboard: expected events with the cycle they must appear in
    typedef struct {int cyc; int a; int d;} ev_t;
    ev_t wq[$];
    ev_t rq[$];
    ev_t eq[$];
    // Reference model: command-level view of the protocol
    int         m_mode = 0;
    int         m_h = 0;
    int         m_drop = -1;
    int         m_errs = 0;
    int         m_a = 0;
    logic       m_ok = 1'b0;
    logic [7:0] m_regs [16];
    function automatic void m_err(int e);
        m_errs = m_errs < 255 ? m_errs + 1 : 255;
        eq.push_back('{cyc: e, a: 0, d: m_errs});
    endfunction
    task automatic model_step(int e, logic v, logic [7:0] d, logic rdy);
        if (m_mode == 0) begin
            if (v) begin
                if (e <= m_drop || d[6:4] != 3'b000) m_err(e);
                else begin
                    m_a  = int'(d[3:0]);
                    m_ok = m_a < NR;
                    m_h  = e;
                    if (!m_ok) m_err(e);
                    if (d[7]) m_mode = 1;
                    else begin
                        m_mode = 2;
                        rq.push_back('{cyc: e + 1, a: m_a, d: m_ok ? int'(m_regs[m_a]) : 255});
                    end
                end
            end
        end else if (m_mode == 1) begin
            if (v) begin
                if (m_ok) begin
                    m_regs[m_a] = d;
                    wq.push_back('{cyc: e, a: m_a, d: int'(d)});
                end
                m_drop = e + 1;
                m_mode = 0;
            end else if (e == m_h + TO) begin
                m_err(e);
                m_mode = 0;
            end
        end else begin
            if (v) m_err(e);
            if (e >= m_h + 2 && rdy) m_mode = 0;
        end
    endtask
    task automatic tick(logic v, logic [7:0] d, logic rdy);
        int e;
        e = cyc + 1;
        rx_valid = v;
        rx_data  = d;
        tx_ready = rdy;
        model_step(e, v, d, rdy);
        @(posedge clk);
        #1;
    endtask
    task automatic idle(int n, logic rdy);
        for (int i = 0; i < n; i++) tick(1'b0, 8'd0, rdy);
    endtask
    task automatic do_reset();
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        m_mode = 0;
        m_drop = -1;
        m_errs = 0;
        wq.delete();
        rq.delete();
        eq.delete();
        @(posedge clk);
        #1;
        check("reset_outputs", {tx_valid, tx_data, reg_addr, reg_wdata, reg_we, cmd_error, err_count}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask
    // Monitor: pops and compares whenever the DUT presents an event
    logic tv_prev = 1'b0;
    ev_t  mev;
    always @(negedge clk) begin
        if (!reset_n) tv_prev = 1'b0;
        else begin
            if (reg_we) begin
                check("we_expected", 32'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    mev = wq.pop_front();
                    check("we_cycle", cyc, mev.cyc);
                    check("we_addr", 32'(reg_addr), mev.a);
                    check("we_data", 32'(reg_wdata), mev.d);
                end
            end
            if (tx_valid) begin
                check("tx_expected", 32'(rq.size() != 0), 1);
                if (rq.size() != 0) begin
                    if (!tv_prev) check("tx_rise_cycle", cyc, rq[0].cyc);
                    check("tx_data", 32'(tx_data), rq[0].d);
                    if (tx_ready) rq.delete(0);
                end
            end
            if (cmd_error) begin
                check("err_expected", 32'(eq.size() != 0), 1);
                if (eq.size() != 0) begin
                    mev = eq.pop_front();
                    check("err_cycle", cyc, mev.cyc);
                    check("err_count", 32'(err_count), mev.d);
                end
            end
            tv_prev = tx_valid;
        end
    end
    initial begin
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            m_regs[i] = b;
            regmem[i] = b;
        end
        m_regs[5] = 8'h5C;
        regmem[5] = 8'h5C;
        do_reset();
        // Write 0x83, 0x2A with a gap
        tick(1'b1, 8'h83, 1'b0);
        idle($urandom_range(0, 20), 1'b0);
        tick(1'b1, 8'h2A, 1'b0);
        idle(2, 1'b0);
        check("wr_addr", 32'(reg_addr), 3);
        check("wr_data", 32'(reg_wdata), 32'h2A);
        check("wr_errs", 32'(err_count), 0);
        // Read with backpressure
        tick(1'b1, 8'h05, 1'b0);
        idle(11, 1'b0);
        tick(1'b0, 8'd0, 1'b1);
        idle(3, 1'b1);
        check("rd_done", 32'(rq.size()), 0);
        // Bad header, then read of an out-of-range address
        tick(1'b1, 8'h40, 1'b0);
        tick(1'b1, 8'h0C, 1'b0);
        idle(4, 1'b1);
        check("bad_errs", 32'(err_count), 2);
        // Timeout, then a normal read, then data on the last allowed cycle
        tick(1'b1, 8'h81, 1'b0);
        idle(TO + 2, 1'b0);
        tick(1'b1, 8'h02, 1'b0);
        idle(4, 1'b1);
        tick(1'b1, 8'h81, 1'b0);
        idle(TO - 1, 1'b0);
        tick(1'b1, 8'h66, 1'b0);
        idle(2, 1'b0);
        check("late_wdata", 32'(reg_wdata), 32'h66);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            b = r < 4 ? {4'b1000, 4'($urandom)} : r < 8 ? {4'b0000, 4'($urandom)} :
                r == 8 ? {1'($urandom), 3'($urandom_range(1, 7)), 4'($urandom)} : 8'($urandom);
            tick($urandom_range(0, 2) == 0, b, 1'($urandom));
        end
        idle(8, 1'b1);
        // Reset while in SEND and while in GET_DATA
        tick(1'b1, 8'h03, 1'b0);
        idle(4, 1'b0);
        do_reset();
        idle(5, 1'b1);
        check("post_reset_tx", 32'(tx_valid), 0);
        tick(1'b1, 8'h84, 1'b0);
        idle(2, 1'b0);
        do_reset();
        idle(5, 1'b0);
        check("post_reset_errs", 32'(err_count), 0);
        // Error counter saturation
        for (int i = 0; i < 260; i++)
            tick(1'b1, {1'($urandom), 3'($urandom_range(1, 7)), 4'($urandom)}, 1'b0);
        idle(3, 1'b0);
        check("err_saturate", 32'(err_count), 255);
        check("queues_empty", 32'(wq.size() + rq.size() + eq.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
